// File: rtl/cmd_initiator.sv
// cmd_initiator: serializes a memory request into the 4-byte device command word,
//   then streams buffered write payload to the device or returns read response bytes.
// Latency: reset op accepted in cycle 0, bytes in cycles 1-4, o_done in cycle 5.
// Backpressure: device pushes stall on i_dev_input_full; reads stall on empty or !i_rd_ready.
//
// Ports:
//   i_clk, i_rst_n                         clock, synchronous active-low reset
//   i_req_valid/o_req_ready, i_req_op/addr/size   request handshake (ready only in IDLE)
//   i_wr_valid/o_wr_ready, i_wr_data       write payload, taken while filling the buffer
//   o_rd_valid/i_rd_ready, o_rd_data       read bytes returned to the user
//   o_dev_data_valid/o_dev_data, i_dev_input_full      device input byte stream
//   o_dev_data_read, i_dev_data, i_dev_output_empty    device output FIFO (FWFT)
//   o_busy, o_done, o_err                  status; o_err qualifies the o_done pulse
// Optional: define CMD_INITIATOR_TIMEOUT_EN to abort a stalled read after TIMEOUT_CYCLES.
module cmd_initiator #(
  parameter int MAX_BURST = 16
`ifdef CMD_INITIATOR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [13:0] i_req_addr,
  input  logic [13:0] i_req_size,
  input  logic        i_wr_valid,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  input  logic        i_rd_ready,
  output logic        o_dev_data_valid,
  output logic [7:0]  o_dev_data,
  input  logic        i_dev_input_full,
  output logic        o_dev_data_read,
  input  logic [7:0]  i_dev_data,
  input  logic        i_dev_output_empty,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {IDLE, FILL, CMD, PAYLOAD, RESP, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    op_q;
  logic [13:0]   addr_q, size_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic [7:0]    wbuf [MAX_BURST];
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;

  logic          accept, req_bad, push, pull, fill_we, cnt_last, tmo;
  logic [14:0]   size_p1, addr_end;
  logic [31:0]   cmd_word;

  assign accept   = i_req_valid && (state == IDLE);
  // 15-bit sums so a request ending past the top address cannot wrap and look legal
  assign size_p1  = {1'b0, i_req_size} + 15'd1;
  assign addr_end = {1'b0, i_req_addr} + {1'b0, i_req_size};
  assign req_bad  = (i_req_op == 2'd3) ||
                    ((i_req_op != 2'd0) &&
                     ((size_p1 > 15'(MAX_BURST)) || (addr_end > 15'd16383)));

  assign cmd_word = {2'b00, op_q, addr_q, size_q};
  assign cnt_last = (14'(cnt) == size_q);
  assign push     = ((state == CMD) || (state == PAYLOAD)) && !i_dev_input_full;
  assign pull     = (state == RESP) && !i_dev_output_empty && (!rd_valid_q || i_rd_ready);
  assign fill_we  = (state == FILL) && i_wr_valid;

`ifdef CMD_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  // Counts consecutive RESP cycles without a device read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (state != RESP) || pull) tmo_cnt <= '0;
    else                                     tmo_cnt <= tmo_cnt + TW'(1);
  end
  assign tmo = (state == RESP) && !pull && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) begin
                 if (req_bad)               state_nxt = DONE;
                 else if (i_req_op == 2'd2) state_nxt = FILL;
                 else                       state_nxt = CMD;
               end
      FILL:    if (fill_we && cnt_last) state_nxt = CMD;
      CMD:     if (push && (cnt[1:0] == 2'd3)) begin
                 case (op_q)
                   2'd0:    state_nxt = DONE;
                   2'd1:    state_nxt = RESP;
                   default: state_nxt = PAYLOAD;
                 endcase
               end
      PAYLOAD: if (push && cnt_last) state_nxt = DONE;
      RESP:    if ((pull && cnt_last) || tmo) state_nxt = DONE;
      // hold completion until the last read byte has been taken by the user
      DONE:    if (!rd_valid_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, shared byte counter and read output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= i_req_op;
        addr_q <= i_req_addr;
        size_q <= i_req_size;
        err_q  <= req_bad;
      end else if (tmo) begin
        err_q  <= 1'b1;
      end
      // one counter serves every phase; it restarts on each state change
      if (state_nxt != state)           cnt <= '0;
      else if (fill_we || push || pull) cnt <= cnt + CW'(1);
      if (pull) begin
        rd_data_q  <= i_dev_data;
        rd_valid_q <= 1'b1;
      end else if (i_rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  // Write payload buffer; whole burst is held before the command goes out
  always_ff @(posedge i_clk) begin
    if (fill_we) wbuf[cnt[IW-1:0]] <= i_wr_data;
  end

  // Output logic
  always_comb begin
    o_req_ready      = (state == IDLE);
    o_busy           = (state != IDLE);
    o_wr_ready       = (state == FILL);
    o_dev_data_valid = push;
    o_dev_data_read  = pull;
    o_dev_data       = 8'h00;
    if (state == CMD) begin
      case (cnt[1:0])
        2'd0:    o_dev_data = cmd_word[7:0];
        2'd1:    o_dev_data = cmd_word[15:8];
        2'd2:    o_dev_data = cmd_word[23:16];
        default: o_dev_data = cmd_word[31:24];
      endcase
    end else if (state == PAYLOAD) begin
      o_dev_data = wbuf[cnt[IW-1:0]];
    end
    o_done = (state == DONE) && !rd_valid_q;
    o_err  = (state == DONE) && !rd_valid_q && err_q;
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_cmd_initiator.sv
module tb_cmd_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [13:0] req_addr = '0;
  logic [13:0] req_size = '0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready = 1'b1;
  logic        dev_valid;
  logic [7:0]  dev_data_out;
  logic        dev_full = 1'b0;
  logic        dev_read;
  logic [7:0]  dev_head;
  logic        dev_empty;
  logic        busy, done, err;

  always #5 clk = ~clk;

  cmd_initiator #(.MAX_BURST(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
    .o_dev_data_valid(dev_valid), .o_dev_data(dev_data_out), .i_dev_input_full(dev_full),
    .o_dev_data_read(dev_read), .i_dev_data(dev_head), .i_dev_output_empty(dev_empty),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard queues
  logic [7:0] exp_dev_q[$];
  logic [7:0] exp_rd_q[$];
  logic       exp_err_q[$];
  int         push_cyc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  // device output FIFO model (first-word fall-through)
  logic [7:0] dev_mem [64];
  int         dev_wp = 0;
  int         dev_rp = 0;
  logic       pop_dev = 1'b0;
  assign dev_head  = dev_mem[dev_rp];
  assign dev_empty = (dev_rp == dev_wp);
  always @(posedge clk) if (pop_dev) dev_rp <= dev_rp + 1;

  logic rd_toggle = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rd_toggle) rd_ready = ~rd_ready;
    else           rd_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor: samples on the falling edge, compares against queued expectations
  always @(negedge clk) begin
    logic [7:0] e;
    logic       ee;
    pop_dev = rst_n && dev_read;
    if (rst_n) begin
      if (dev_full) chk("valid_while_full", {31'd0, dev_valid}, 32'd0);
      if (dev_valid) begin
        push_cyc_q.push_back(cyc);
        if (exp_dev_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dev_push unexpected byte got=%02h", dev_data_out);
        end else begin
          e = exp_dev_q.pop_front();
          chk("dev_byte", {24'd0, dev_data_out}, {24'd0, e});
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_byte unexpected got=%02h", rd_data);
        end else begin
          e = exp_rd_q.pop_front();
          chk("rd_byte", {24'd0, rd_data}, {24'd0, e});
        end
      end
      if (err && !done) chk("err_without_done", {31'd0, err}, 32'd0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done unexpected err=%0d", err);
        end else begin
          ee = exp_err_q.pop_front();
          chk("done_err", {31'd0, err}, {31'd0, ee});
        end
      end
    end
  end

  task automatic exp4(input logic [7:0] b0, b1, b2, b3);
    exp_dev_q.push_back(b0); exp_dev_q.push_back(b1);
    exp_dev_q.push_back(b2); exp_dev_q.push_back(b3);
  endtask

  task automatic dev_load(input logic [7:0] b);
    dev_mem[dev_wp] = b;
    dev_wp++;
  endtask

  // called at posedge+1; returns at posedge+1 right after the accept edge
  task automatic send_req(input logic [1:0] op, input logic [13:0] addr, input logic [13:0] size,
                          output int acc);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
    @(negedge clk);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL done_wait got=%0d exp=%0d", done_cnt, target);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int n;
    int dn;
    int pc;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_dev_valid", {31'd0, dev_valid}, 32'd0);
    chk("rst_dev_read",  {31'd0, dev_read},  32'd0);
    chk("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    chk("rst_wr_ready",  {31'd0, wr_ready},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dn = 0;

    // reset op: 00 00 00 00, done in cycle 5
    push_cyc_q.delete();
    exp4(8'h00, 8'h00, 8'h00, 8'h00);
    exp_err_q.push_back(1'b0);
    send_req(2'd0, 14'h0000, 14'd0, acc);
    dn++; wait_done(dn);
    chk("rstop_latency", done_cyc - acc, 32'd5);
    chk("rstop_pushes", push_cyc_q.size(), 32'd4);

    // write: junk byte during accept must be ignored
    push_cyc_q.delete();
    exp4(8'h03, 8'h00, 8'h04, 8'h20);
    exp4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    exp_err_q.push_back(1'b0);
    wr_valid = 1'b1; wr_data = 8'hEE;
    send_req(2'd2, 14'h0010, 14'd3, acc);
    wr_data = 8'hAA; @(posedge clk); #1;
    wr_data = 8'hBB; @(posedge clk); #1;
    wr_data = 8'hCC; @(posedge clk); #1;
    wr_data = 8'hDD; @(posedge clk); #1;
    wr_valid = 1'b0;
    dn++; wait_done(dn);
    chk("write_latency", done_cyc - acc, 32'd13);
    chk("write_pushes", push_cyc_q.size(), 32'd8);
    if (push_cyc_q.size() == 8) chk("write_back_to_back", push_cyc_q[7] - push_cyc_q[0], 32'd7);

    // read with toggling user ready
    push_cyc_q.delete();
    exp4(8'h03, 8'h00, 8'h04, 8'h10);
    dev_load(8'h11); dev_load(8'h22); dev_load(8'h33); dev_load(8'h44);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22);
    exp_rd_q.push_back(8'h33); exp_rd_q.push_back(8'h44);
    exp_err_q.push_back(1'b0);
    rd_toggle = 1'b1;
    send_req(2'd1, 14'h0010, 14'd3, acc);
    dn++; wait_done(dn);
    rd_toggle = 1'b0;
    chk("read_pushes", push_cyc_q.size(), 32'd4);
    chk("read_fifo_drained", dev_wp - dev_rp, 32'd0);

    // backpressure after command byte 1 for 5 cycles
    push_cyc_q.delete();
    exp4(8'h03, 8'h00, 8'h04, 8'h00);
    exp_err_q.push_back(1'b0);
    send_req(2'd0, 14'h0010, 14'd3, acc);
    n = 0;
    while (push_cyc_q.size() < 2 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("bp_reached_byte1", push_cyc_q.size(), 32'd2);
    dev_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", {24'd0, dev_data_out}, 32'h04);
    end
    @(posedge clk); #1;
    dev_full = 1'b0;
    dn++; wait_done(dn);
    chk("bp_pushes", push_cyc_q.size(), 32'd4);
    chk("bp_latency", done_cyc - acc, 32'd10);

    // rejects: oversize burst, address overflow, illegal op
    for (int k = 0; k < 3; k++) begin
      logic [1:0]  rop;
      logic [13:0] raddr, rsize;
      case (k)
        0:       begin rop = 2'd1; raddr = 14'h0000; rsize = 14'd16; end
        1:       begin rop = 2'd1; raddr = 14'h3FFF; rsize = 14'd1;  end
        default: begin rop = 2'd3; raddr = 14'h0000; rsize = 14'd0;  end
      endcase
      pc = push_cyc_q.size();
      exp_err_q.push_back(1'b1);
      send_req(rop, raddr, rsize, acc);
      dn++; wait_done(dn);
      chk("reject_latency", done_cyc - acc, 32'd1);
      chk("reject_no_push", push_cyc_q.size(), pc);
    end

    // boundary accepted: last legal address range
    push_cyc_q.delete();
    exp4(8'h01, 8'h80, 8'hFF, 8'h1F);
    dev_load(8'h5A); dev_load(8'hA5);
    exp_rd_q.push_back(8'h5A); exp_rd_q.push_back(8'hA5);
    exp_err_q.push_back(1'b0);
    send_req(2'd1, 14'h3FFE, 14'd1, acc);
    dn++; wait_done(dn);
    chk("edge_pushes", push_cyc_q.size(), 32'd4);

    repeat (3) @(posedge clk);
    chk("left_dev_bytes", exp_dev_q.size(), 32'd0);
    chk("left_rd_bytes",  exp_rd_q.size(),  32'd0);
    chk("left_dones",     exp_err_q.size(), 32'd0);
    chk("done_count",     done_cnt,         dn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
